hilo_md_unit: RTL and testbench

//   Producer of the architectural HI/LO register pair read by the ALU through MFHI/MFLO.

---
 rtl/hilo_md_unit_pkg.sv | 24 ++
 rtl/div_radix2.sv | 88 ++++++++
 rtl/hilo_md_unit.sv | 135 +++++++++++++
 tb/tb_hilo_md_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_md_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md_defs : op encodings and FSM state type for the HI/LO multiply/divide unit
// Rev 1.0
// ----------------------------------------------------------------------------
package md_defs;

   localparam int DEF_DATA_W = 32;

   localparam logic [2:0] MD_MTHI  = 3'd0;
   localparam logic [2:0] MD_MTLO  = 3'd1;
   localparam logic [2:0] MD_MULT  = 3'd2;
   localparam logic [2:0] MD_MULTU = 3'd3;
   localparam logic [2:0] MD_DIV   = 3'd4;
   localparam logic [2:0] MD_DIVU  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

endpackage
`default_nettype wire

// File: rtl/div_radix2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_radix2 : unsigned restoring divider, one quotient bit per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
module div_radix2 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int              CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] dvsr_q, dvsr_d;

   logic [DATA_W:0]   shift;
   logic              ge;
   logic [DATA_W-1:0] rem_step;
   logic [DATA_W-1:0] quo_step;

   // done and the results are the outcome of the iteration in flight, so the
   // parent can commit them on the same edge that finishes the last iteration.
   always_comb begin
      shift    = {rem_q, quo_q[DATA_W-1]};
      ge       = (shift >= {1'b0, dvsr_q});
      rem_step = ge ? (shift[DATA_W-1:0] - dvsr_q) : shift[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], ge};
      done     = busy_q && (cnt_q == LAST);

      busy_d = busy_q;
      cnt_d  = cnt_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvsr_d = dvsr_q;
      if (abort) begin
         busy_d = 1'b0;
      end else if (start) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         quo_d  = dividend;
         rem_d  = '0;
         dvsr_d = divisor;
      end else if (busy_q) begin
         rem_d = rem_step;
         quo_d = quo_step;
         cnt_d = cnt_q + CNT_W'(1);
         if (done) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvsr_q <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvsr_q <= dvsr_d;
      end
   end

   assign busy      = busy_q;
   assign quotient  = quo_step;
   assign remainder = rem_step;

endmodule
`default_nettype wire

// File: rtl/hilo_md_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hilo_md_unit : HI/LO register pair with MTHI/MTLO, MULT(U) and DIV(U)
// Rev 1.0
// ----------------------------------------------------------------------------
module hilo_md_unit
   import md_defs::*;
#(
   parameter int              DATA_W   = DEF_DATA_W,
   parameter logic [DATA_W-1:0] HILO_RST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   input  logic [2:0]        md_op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              flush,
   output logic              stall,
   output logic              div_done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   md_state_e         state_q, state_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic              rneg_q, rneg_d;
   logic              qneg_q, qneg_d;
   logic              div_done_q, div_done_d;

   logic                is_div;
   logic                is_signed;
   logic                div_start;
   logic                div_abort;
   logic                div_busy;
   logic                div_fin;
   logic [DATA_W-1:0]   a_mag;
   logic [DATA_W-1:0]   b_mag;
   logic [DATA_W-1:0]   div_quo;
   logic [DATA_W-1:0]   div_rem;
   logic [2*DATA_W-1:0] prod_s;
   logic [2*DATA_W-1:0] prod_u;

   always_comb begin
      is_div    = op_valid && ((md_op == MD_DIV) || (md_op == MD_DIVU));
      is_signed = (md_op == MD_DIV);
      a_mag     = (is_signed && a[DATA_W-1]) ? (-a) : a;
      b_mag     = (is_signed && b[DATA_W-1]) ? (-b) : b;
      div_start = (state_q == ST_IDLE) && is_div && !flush;
      div_abort = (state_q == ST_BUSY) && flush;
      prod_s    = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
      prod_u    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
   end

   div_radix2 #(
      .DATA_W (DATA_W)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .abort     (div_abort),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .busy      (div_busy),
      .done      (div_fin),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // A zero divisor leaves the quotient all ones and the remainder at |a|;
   // suppressing the quotient negation and re-applying a's sign returns a.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      rneg_d  = rneg_q;
      qneg_d  = qneg_q;
      case (state_q)
         ST_IDLE: begin
            if (op_valid && !flush) begin
               case (md_op)
                  MD_MTHI:  hi_d = a;
                  MD_MTLO:  lo_d = a;
                  MD_MULT:  {hi_d, lo_d} = prod_s;
                  MD_MULTU: {hi_d, lo_d} = prod_u;
                  MD_DIV, MD_DIVU: begin
                     rneg_d  = is_signed && a[DATA_W-1];
                     qneg_d  = is_signed && (a[DATA_W-1] ^ b[DATA_W-1]) && (b != '0);
                     state_d = ST_BUSY;
                  end
                  default: ;
               endcase
            end
         end
         ST_BUSY: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (div_fin) begin
               lo_d    = qneg_q ? (-div_quo) : div_quo;
               hi_d    = rneg_q ? (-div_rem) : div_rem;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      div_done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         hi_q       <= HILO_RST;
         lo_q       <= HILO_RST;
         rneg_q     <= 1'b0;
         qneg_q     <= 1'b0;
         div_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         rneg_q     <= rneg_d;
         qneg_q     <= qneg_d;
         div_done_q <= div_done_d;
      end
   end

   assign stall    = ((state_q == ST_IDLE) && is_div) || div_busy;
   assign div_done = div_done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_md_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hilo_md_unit : scoreboard bench for the HI/LO multiply/divide unit
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hilo_md_unit;
   import md_defs::*;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } res_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         op_valid = 1'b0;
   logic [2:0]   md_op = 3'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         flush = 1'b0;
   logic         stall;
   logic         div_done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   res_t         sb_q[$];
   int           n_cmp = 0;
   int           n_err = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   always #5 clk = ~clk;

   hilo_md_unit #(.DATA_W(W), .HILO_RST('0)) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .md_op    (md_op),
      .a        (a),
      .b        (b),
      .flush    (flush),
      .stall    (stall),
      .div_done (div_done),
      .hi       (hi),
      .lo       (lo)
   );

   function automatic res_t div_model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      res_t r;
      int   sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      if (y == '0)                                r = {x, 32'hFFFF_FFFF};
      else if (op == MD_DIVU)                     r = {x % y, x / y};
      else if (x == 32'h8000_0000 && y == '1)     r = {32'h0, 32'h8000_0000};
      else                                        r = {32'(sx % sy), 32'(sx / sy)};
      return r;
   endfunction

   task automatic drive_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
      md_op = op; a = av; b = bv; op_valid = 1'b1;
      sb_q.push_back({eh, el});
      m_hi = eh; m_lo = el;
   endtask

   // Issues a divide at the current negedge and returns at the negedge of the
   // DONE cycle (op_valid still held), or after the cycle budget expires.
   task automatic run_div(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          output int stalls, output int dones);
      drive_op(op, av, bv, eh, el);
      stalls = 0; dones = 0;
      #1;
      if (stall === 1'b1) stalls++;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (stall === 1'b1) stalls++;
         if (div_done === 1'b1) begin
            dones++;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp += 4;
      if (hi !== '0)          begin n_err++; $display("FAIL reset_hi: got %h expected 0", hi); end
      if (lo !== '0)          begin n_err++; $display("FAIL reset_lo: got %h expected 0", lo); end
      if (stall !== 1'b0)     begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
      if (div_done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b expected 0", div_done); end
      rst = 1'b1;
      m_hi = '0; m_lo = '0;
   endtask

   task automatic test_moves;
      res_t e;
      drive_op(MD_MTHI, 32'h1234_5678, '0, 32'h1234_5678, m_lo);
      #1; n_cmp++;
      if (stall !== 1'b0) begin n_err++; $display("FAIL mthi_stall: got %b expected 0", stall); end
      @(negedge clk); op_valid = 1'b0;
      e = sb_q.pop_front(); n_cmp += 2;
      if (hi !== e.hi) begin n_err++; $display("FAIL mthi_hi: got %h expected %h", hi, e.hi); end
      if (lo !== e.lo) begin n_err++; $display("FAIL mthi_lo: got %h expected %h", lo, e.lo); end
      drive_op(MD_MTLO, 32'h9ABC_DEF0, '0, m_hi, 32'h9ABC_DEF0);
      #1; n_cmp++;
      if (stall !== 1'b0) begin n_err++; $display("FAIL mtlo_stall: got %b expected 0", stall); end
      @(negedge clk); op_valid = 1'b0;
      e = sb_q.pop_front(); n_cmp += 2;
      if (hi !== e.hi) begin n_err++; $display("FAIL mtlo_hi: got %h expected %h", hi, e.hi); end
      if (lo !== e.lo) begin n_err++; $display("FAIL mtlo_lo: got %h expected %h", lo, e.lo); end
      // A flushed move must leave HI untouched.
      flush = 1'b1;
      drive_op(MD_MTHI, 32'hDEAD_BEEF, '0, m_hi, m_lo);
      @(negedge clk); op_valid = 1'b0; flush = 1'b0;
      e = sb_q.pop_front(); n_cmp += 2;
      if (hi !== e.hi) begin n_err++; $display("FAIL flush_idle_hi: got %h expected %h", hi, e.hi); end
      if (lo !== e.lo) begin n_err++; $display("FAIL flush_idle_lo: got %h expected %h", lo, e.lo); end
   endtask

   task automatic test_mult;
      res_t         e;
      logic [W-1:0] av, bv;
      longint       ps;
      logic [63:0]  pu;
      drive_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      @(negedge clk); op_valid = 1'b0;
      e = sb_q.pop_front(); n_cmp += 2;
      if (hi !== e.hi) begin n_err++; $display("FAIL mult_hi: got %h expected %h", hi, e.hi); end
      if (lo !== e.lo) begin n_err++; $display("FAIL mult_lo: got %h expected %h", lo, e.lo); end
      drive_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
      @(negedge clk); op_valid = 1'b0;
      e = sb_q.pop_front(); n_cmp += 2;
      if (hi !== e.hi) begin n_err++; $display("FAIL multu_hi: got %h expected %h", hi, e.hi); end
      if (lo !== e.lo) begin n_err++; $display("FAIL multu_lo: got %h expected %h", lo, e.lo); end
      for (int i = 0; i < 6; i++) begin
         av = $urandom; bv = $urandom;
         if (i % 2 == 0) begin
            ps = longint'($signed(av)) * longint'($signed(bv));
            drive_op(MD_MULT, av, bv, ps[63:32], ps[31:0]);
         end else begin
            pu = {32'h0, av} * {32'h0, bv};
            drive_op(MD_MULTU, av, bv, pu[63:32], pu[31:0]);
         end
         @(negedge clk); op_valid = 1'b0;
         e = sb_q.pop_front(); n_cmp += 2;
         if (hi !== e.hi) begin n_err++; $display("FAIL mult_rand%0d_hi: got %h expected %h", i, hi, e.hi); end
         if (lo !== e.lo) begin n_err++; $display("FAIL mult_rand%0d_lo: got %h expected %h", i, lo, e.lo); end
      end
   endtask

   task automatic check_div(input string name, input logic [2:0] op, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic [W-1:0] eh, input logic [W-1:0] el);
      res_t e;
      int   stalls, dones;
      run_div(op, av, bv, eh, el, stalls, dones);
      e = sb_q.pop_front(); n_cmp += 4;
      if (dones != 1)   begin n_err++; $display("FAIL %s_done: got %0d pulses expected 1", name, dones); end
      if (stalls != 33) begin n_err++; $display("FAIL %s_stall_len: got %0d expected 33", name, stalls); end
      if (hi !== e.hi)  begin n_err++; $display("FAIL %s_hi: got %h expected %h", name, hi, e.hi); end
      if (lo !== e.lo)  begin n_err++; $display("FAIL %s_lo: got %h expected %h", name, lo, e.lo); end
      @(negedge clk); op_valid = 1'b0;
      #1; n_cmp += 2;
      if (stall !== 1'b0)    begin n_err++; $display("FAIL %s_reissue: stall got %b expected 0", name, stall); end
      if (div_done !== 1'b0) begin n_err++; $display("FAIL %s_pulse_width: div_done got %b expected 0", name, div_done); end
      @(negedge clk);
   endtask

   task automatic test_div_signed;
      check_div("div_s", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
   endtask

   task automatic test_boundaries;
      check_div("divu_by0", MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
      check_div("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      check_div("div_by0_neg", MD_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
   endtask

   task automatic test_back_to_back;
      res_t         r;
      logic [W-1:0] av, bv;
      logic [2:0]   op;
      for (int i = 0; i < 4; i++) begin
         av = $urandom;
         bv = $urandom_range(1, 1000);
         if (i >= 2) bv = -bv;
         op = (i % 2 == 0) ? MD_DIV : MD_DIVU;
         r  = div_model(op, av, bv);
         check_div($sformatf("div_rand%0d", i), op, av, bv, r.hi, r.lo);
      end
   endtask

   task automatic test_flush;
      int dones;
      // Flush in the issue cycle: the divide never starts.
      flush = 1'b1;
      md_op = MD_DIV; a = 32'd100; b = 32'd7; op_valid = 1'b1;
      @(negedge clk); flush = 1'b0; op_valid = 1'b0;
      #1; n_cmp++;
      if (stall !== 1'b0) begin n_err++; $display("FAIL flush_issue_stall: got %b expected 0", stall); end
      @(negedge clk);
      // Flush during BUSY iteration 10.
      md_op = MD_DIV; a = 32'd100; b = 32'd7; op_valid = 1'b1;
      repeat (10) @(negedge clk);
      flush = 1'b1; op_valid = 1'b0;
      @(negedge clk); flush = 1'b0;
      #1; n_cmp += 3;
      if (stall !== 1'b0) begin n_err++; $display("FAIL flush_busy_stall: got %b expected 0", stall); end
      if (hi !== m_hi)    begin n_err++; $display("FAIL flush_busy_hi: got %h expected %h", hi, m_hi); end
      if (lo !== m_lo)    begin n_err++; $display("FAIL flush_busy_lo: got %h expected %h", lo, m_lo); end
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (div_done === 1'b1) dones++;
      end
      n_cmp += 2;
      if (dones != 0)                   begin n_err++; $display("FAIL flush_late_done: got %0d pulses expected 0", dones); end
      if (hi !== m_hi || lo !== m_lo)   begin n_err++; $display("FAIL flush_late_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
   endtask

   task automatic test_reset_abort;
      int dones;
      md_op = MD_DIVU; a = 32'd1000; b = 32'd3; op_valid = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0; op_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      m_hi = '0; m_lo = '0;
      #1; n_cmp += 4;
      if (hi !== '0)         begin n_err++; $display("FAIL rst_abort_hi: got %h expected 0", hi); end
      if (lo !== '0)         begin n_err++; $display("FAIL rst_abort_lo: got %h expected 0", lo); end
      if (stall !== 1'b0)    begin n_err++; $display("FAIL rst_abort_stall: got %b expected 0", stall); end
      if (div_done !== 1'b0) begin n_err++; $display("FAIL rst_abort_done: got %b expected 0", div_done); end
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (div_done === 1'b1) dones++;
      end
      n_cmp += 2;
      if (dones != 0)                 begin n_err++; $display("FAIL rst_abort_late_done: got %0d pulses expected 0", dones); end
      if (hi !== '0 || lo !== '0)     begin n_err++; $display("FAIL rst_abort_late_hilo: got %h_%h expected 0_0", hi, lo); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_moves();
      test_mult();
      test_div_signed();
      test_boundaries();
      test_back_to_back();
      test_flush();
      test_reset_abort();
      n_cmp++;
      if (sb_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
